// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage payload widths, bubble encodings and
// occupancy codes for the valid/ready skid stages.
package pipe_pkg;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  localparam int unsigned IF_ID_W  = 64;
  localparam int unsigned ID_EX_W  = 160;
  localparam int unsigned EX_MEM_W = 128;
  localparam int unsigned MEM_WB_W = 96;

  // IF/ID payload is {PC, instruction}; a bubble carries PC=0 and an ADDI x0 NOP
  localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE = {32'h0, RV32_NOP};

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_encode(input logic main_v, input logic skid_v);
    return skid_v ? OCC_FULL : (main_v ? OCC_ONE : OCC_EMPTY);
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready handshake and a 2-entry
// skid buffer; in_ready is registered so no ready path crosses the stage.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W       = IF_ID_W,
  parameter logic [DATA_W-1:0] BUBBLE_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              in_ready_q,   in_ready_d;
  logic [1:0]        occ_q;
  logic              acc, con;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= BUBBLE_VALUE;
      skid_valid_q <= 1'b0;
      skid_data_q  <= BUBBLE_VALUE;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  always_comb begin
    occ_q        = occ_encode(main_valid_q, skid_valid_q);
    acc          = in_valid & in_ready_q;
    con          = main_valid_q & out_ready;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      // Offered data is dropped even when acc is high; a con still completes downstream
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE_VALUE;
      skid_valid_d = 1'b0;
      skid_data_d  = BUBBLE_VALUE;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (acc) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
          end
        end
        OCC_ONE: begin
          if (acc && con) begin
            main_data_d = in_data;
          end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
          end else if (con) begin
            main_valid_d = 1'b0;
            main_data_d  = BUBBLE_VALUE;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only a drain can happen
          if (con) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_data_d  = BUBBLE_VALUE;
          end
        end
        default: ;
      endcase
    end
    in_ready_d = ~skid_valid_d;
  end

  always_comb begin
    out_valid = main_valid_q;
    out_data  = main_data_q;
    in_ready  = in_ready_q;
    occupancy = occ_q;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed 64-bit IF/ID register: a generic pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.
- Sustains one transfer per cycle under back-pressure, with a registered in_ready (no combinational ready path upstream).
- Supports synchronous flush with bubble insertion.
- Instantiated between every pipeline stage (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing stall-based freeze registers.

Parameters:
- DATA_W, 64, payload width in bits (IF/ID instance: {PC, instruction}).
- BUBBLE_VALUE, {DATA_W{1'b0}}, value driven on out_data when out_valid=0, and after reset or flush.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; discards all held and incoming data.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry holds valid data.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to next stage.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main register (drives out_data/out_valid) plus skid register (skid_data, skid_valid).
- Handshakes:
  - Input accept: acc = in_valid & in_ready.
  - Output consume: con = out_valid & out_ready.
- States, encoded by occupancy:
  - EMPTY: out_valid=0, skid_valid=0.
  - ONE: out_valid=1, skid_valid=0.
  - FULL: out_valid=1, skid_valid=1.
- Transitions:
  - EMPTY, acc → ONE; main <= in_data.
  - ONE, acc & con → ONE; main <= in_data.
  - ONE, acc & !con → FULL; skid <= in_data.
  - ONE, !acc & con → EMPTY; main <= BUBBLE_VALUE.
  - FULL, con → ONE; main <= skid, skid_data <= BUBBLE_VALUE. No acc is possible because in_ready=0.
  - Any state with no acc and no con: hold all registers.
- in_ready is a flop: next value = !(next skid_valid). It is 1 in EMPTY and ONE, 0 in FULL.
- Ordering and throughput:
  - Data leaves in strict FIFO order.
  - No loss or duplication.
  - Latency from acc to out_valid is 1 cycle.
  - Throughput is 1/cycle while out_ready=1.
- out_data equals BUBBLE_VALUE whenever out_valid=0.
- flush (priority below reset, above everything else), on the clock edge:
  - out_valid <= 0, skid_valid <= 0.
  - out_data and skid_data <= BUBBLE_VALUE.
  - occupancy <= 0, in_ready <= 1.
  - Data offered in the flush cycle is dropped, even if acc=1.
  - A con in the flush cycle still counts as delivered downstream.
- Reset (rst_n=0, asynchronous, any state including FULL):
  - out_valid=0, out_data=BUBBLE_VALUE.
  - skid cleared.
  - in_ready=1, occupancy=0.
  - Release is synchronous to clk; the first accept can occur on the first edge after deassertion.
- in_data is sampled only on acc. in_data may be X when in_valid=0.
- out_ready may toggle freely. out_valid/out_data stay stable while out_valid=1 and out_ready=0.
- No combinational path from out_ready to in_ready.

Decomposition:
- Shared package pipe_pkg:
  - RV32_NOP = 32'h0000_0013, used to build the IF/ID BUBBLE_VALUE {32'h0, RV32_NOP}.
  - Occupancy localparams OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
  - Per-stage payload width constants (IF_ID_W=64, etc.).
- No sub-module; the block is a single flat module. Stages chain by direct instantiation.

Test Plan:
- Reset mid-FULL: fill with 0xA, 0xB under out_ready=0, then pulse rst_n=0 asynchronously → immediately out_valid=0, out_data=BUBBLE, in_ready=1, occupancy=0.
- Streaming: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 → out_data 1,2,3,4 one cycle later, out_valid continuous, in_ready stays 1.
- Back-pressure: stream 0x10, 0x11, 0x12, with out_ready=0 from cycle 1 → occupancy 2, in_ready=0, 0x12 held upstream. Raise out_ready → outputs 0x10, 0x11, 0x12 in order, no loss.
- Flush while FULL with in_valid=1 (data 0x55) → next cycle out_valid=0, out_data=BUBBLE_VALUE, occupancy=0, 0x55 never appears.
- Random valid/ready (10k cycles, DATA_W=64 and DATA_W=8) → scoreboard matches FIFO order. Assert in_ready == (occupancy<2) and out_data==BUBBLE whenever !out_valid.
- IF/ID instance with BUBBLE_VALUE={32'h0, RV32_NOP}: flush → out_data[31:0]=32'h00000013, out_data[63:32]=0.
